top_level: RTL and testbench
============================

Name: top_level

Overview:
- Top-level cache subsystem: direct-mapped, write-back, write-allocate cache controller plus an internal behavioural main-memory model.
- The CPU side transfers whole 512-bit (64-byte) lines using a request/done handshake.
- One request is processed at a time. Each request reports exactly one of cache_hit or cache_miss, then done_signal.
- Used as the DUT for hit/miss-rate simulation under random and locality-bounded address streams.

Parameters:
- NUM_LINES, 128: cache lines. Must be a power of 2. INDEX_W = log2(NUM_LINES).
- MEM_LINE_BITS, 12: backing memory holds 2^MEM_LINE_BITS lines, indexed by addr[6+MEM_LINE_BITS-1:6]. Higher address bits alias.
- MEM_LATENCY, 4: cycles per memory line read or line write, ≥1.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- cpu_read, input, 1: read request level. Held until done_signal is seen.
- cpu_write, input, 1: write request level. Same rule. If both are high, write wins.
- cpu_address, input, 32: byte address. [5:0] offset (ignored), [6+INDEX_W-1:6] index, [31:6+INDEX_W] tag.
- cpu_write_data, input, 512: full line written on a write request.
- cpu_read_data, output, 512: line returned. Valid while done_signal is high; held until the next acceptance.
- cache_hit, output, 1: high from tag-check until return to IDLE when the lookup hit.
- cache_miss, output, 1: same as cache_hit, for a miss.
- done_signal, output, 1: request complete. Held high until cpu_read and cpu_write are both low.

Behaviour:
- Storage:
  - Per line: valid, dirty, tag, 512-bit data.
  - Memory array is zero-initialised at time 0.
  - Memory is not affected by rst.
- Reset:
  - All outputs go to 0. FSM goes to IDLE.
  - All valid and dirty bits are cleared.
  - Reset mid-operation aborts the request; a pending writeback is lost.
- IDLE:
  - On a clock edge with cpu_read|cpu_write high, latch address, data and op, then go to TAG_CHECK.
- TAG_CHECK (1 cycle):
  - Hit = valid[idx] && tag match.
  - On hit, set cache_hit:
    - Read: cpu_read_data <= line.
    - Write: line <= cpu_write_data, dirty <= 1, cpu_read_data <= cpu_write_data.
    - Go to DONE.
  - On miss, set cache_miss:
    - If victim is valid && dirty, go to WRITEBACK.
    - Otherwise, read goes to FILL and write goes to INSTALL.
- WRITEBACK:
  - Count MEM_LATENCY cycles, then write the victim line to memory at the victim's tag|index address.
  - Then read goes to FILL and write goes to INSTALL.
- FILL:
  - Count MEM_LATENCY cycles, then install the memory line: valid=1, dirty=0, new tag.
  - cpu_read_data <= line. Go to DONE.
- INSTALL (write miss, 1 cycle):
  - Full-line write, so no memory fetch.
  - Line <= cpu_write_data, valid=1, dirty=1, tag set. cpu_read_data <= data. Go to DONE.
- DONE:
  - done_signal=1.
  - When cpu_read==0 && cpu_write==0, clear done, hit and miss, then go to IDLE.
  - A new request is never accepted before the request lines drop. This makes back-to-back handshakes race-free.
- Latency, counted in edges after the acceptance edge:
  - Hit: hit/miss at +1, done at +2.
  - Clean read miss: done at +2+MEM_LATENCY.
  - Dirty read miss: done at +2+2·MEM_LATENCY.
  - Clean write miss: done at +3.
  - Dirty write miss: done at +3+MEM_LATENCY.
- cache_hit and cache_miss are mutually exclusive and never high in IDLE.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0].
  - Each increments by 1 in the TAG_CHECK cycle on a hit or miss respectively.
  - Both clear on rst and saturate at 0xFFFFFFFF.
- When undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset 5 cycles, then read 0x1000_0000 → cache_miss=1, done after 1+MEM_LATENCY further cycles, cpu_read_data=0.
- Write line 0xA5..A5 to 0x1000_0004, then read 0x1000_0030 → both accesses hit; read returns 0xA5..A5.
- Write 0x1111.. to 0x1000_0000, then read 0x1000_2000 (same index, new tag) → miss with writeback, total 2·MEM_LATENCY stall; then read 0x1000_0000 → miss, data 0x1111.. recovered from memory.
- Write miss to a clean line, e.g. 0x1000_0040 → cache_miss, done 2 cycles after miss, no memory read.
- Hold cpu_read high for 3 cycles after done → no second request accepted; done stays high until the request drops.
- Assert rst during FILL → all outputs 0 next edge; re-read of the same address misses. 5000 locality accesses (64000-byte region, 30% writes) → exactly one of hit/miss per access, and hits + misses = 5000.

Source files
------------

// File: rtl/top_level.sv
// top_level: direct-mapped, write-back, write-allocate cache controller with a
// behavioural backing memory. The CPU side moves whole 64-byte lines through a
// level request / done handshake, with one request in flight at a time.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   cpu_read          read request level, held until done_signal is seen
//   cpu_write         write request level; wins over cpu_read when both are high
//   cpu_address       byte address: [5:0] offset, [6+INDEX_W-1:6] index, rest tag
//   cpu_write_data    full line written by a write request
//   cpu_read_data     returned line, valid with done_signal, held until next accept
//   cache_hit/miss    lookup result, held from tag check until return to idle
//   done_signal       request complete, held until both request lines drop
//
// Optional feature (macro CACHE_STATS_EN): adds saturating 32-bit hit/miss
// counters stat_hits and stat_misses, cleared by rst.
module top_level #(
    parameter int unsigned NUM_LINES     = 128,
    parameter int unsigned MEM_LINE_BITS = 12,
    parameter int unsigned MEM_LATENCY   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_address,
    input  logic [511:0] cpu_write_data,
    output logic [511:0] cpu_read_data,
    output logic         cache_hit,
    output logic         cache_miss,
    output logic         done_signal
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);

    localparam int unsigned LINE_W    = 512;
    localparam int unsigned LADDR_W   = 26;
    localparam int unsigned INDEX_W   = $clog2(NUM_LINES);
    localparam int unsigned TAG_W     = LADDR_W - INDEX_W;
    localparam int unsigned MEM_LINES = 1 << MEM_LINE_BITS;
    localparam int unsigned CNT_W     = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG_CHECK,
        S_WRITEBACK,
        S_FILL,
        S_INSTALL,
        S_DONE
    } state_t;

    state_t state_q;

    // Cache arrays; only valid/dirty are cleared by reset.
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Backing memory: 2-state so it starts all-zero, untouched by reset.
    bit   [LINE_W-1:0]    mem    [MEM_LINES];

    // Latched request.
    logic [LADDR_W-1:0]   req_laddr_q;
    logic [LINE_W-1:0]    req_wdata_q;
    logic                 req_write_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [INDEX_W-1:0]       req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic                     lookup_hit;
    logic                     victim_dirty;
    logic                     mem_done;
    logic [MEM_LINE_BITS-1:0] fill_mi;
    logic [MEM_LINE_BITS-1:0] victim_mi;
    logic                     unused_offset;

    assign req_idx       = req_laddr_q[INDEX_W-1:0];
    assign req_tag       = req_laddr_q[LADDR_W-1:INDEX_W];
    assign lookup_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty  = valid_q[req_idx] && dirty_q[req_idx];
    assign mem_done      = (cnt_q == CNT_W'(MEM_LATENCY - 1));
    // Memory is indexed by the low line-address bits; higher bits alias.
    assign fill_mi       = MEM_LINE_BITS'(req_laddr_q);
    assign victim_mi     = MEM_LINE_BITS'({tag_q[req_idx], req_idx});
    assign unused_offset = ^cpu_address[5:0];

    // Controller FSM, arrays and backing memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            cnt_q         <= '0;
            cpu_read_data <= '0;
            cache_hit     <= 1'b0;
            cache_miss    <= 1'b0;
            done_signal   <= 1'b0;
            req_laddr_q   <= '0;
            req_wdata_q   <= '0;
            req_write_q   <= 1'b0;
`ifdef CACHE_STATS_EN
            stat_hits     <= '0;
            stat_misses   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_read || cpu_write) begin
                        req_laddr_q <= cpu_address[31:6];
                        req_wdata_q <= cpu_write_data;
                        req_write_q <= cpu_write;
                        state_q     <= S_TAG_CHECK;
                    end
                end
                S_TAG_CHECK: begin
                    cnt_q <= '0;
                    if (lookup_hit) begin
                        cache_hit <= 1'b1;
                        if (req_write_q) begin
                            data_q[req_idx]  <= req_wdata_q;
                            dirty_q[req_idx] <= 1'b1;
                            cpu_read_data    <= req_wdata_q;
                        end else begin
                            cpu_read_data    <= data_q[req_idx];
                        end
                        state_q <= S_DONE;
`ifdef CACHE_STATS_EN
                        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
`endif
                    end else begin
                        cache_miss <= 1'b1;
                        if (victim_dirty)     state_q <= S_WRITEBACK;
                        else if (req_write_q) state_q <= S_INSTALL;
                        else                  state_q <= S_FILL;
`ifdef CACHE_STATS_EN
                        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
`endif
                    end
                end
                S_WRITEBACK: begin
                    if (mem_done) begin
                        mem[victim_mi] <= data_q[req_idx];
                        cnt_q          <= '0;
                        state_q        <= req_write_q ? S_INSTALL : S_FILL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FILL: begin
                    if (mem_done) begin
                        data_q[req_idx]  <= mem[fill_mi];
                        tag_q[req_idx]   <= req_tag;
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        cpu_read_data    <= mem[fill_mi];
                        cnt_q            <= '0;
                        state_q          <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_INSTALL: begin
                    // Full-line write: no fetch needed.
                    data_q[req_idx]  <= req_wdata_q;
                    tag_q[req_idx]   <= req_tag;
                    valid_q[req_idx] <= 1'b1;
                    dirty_q[req_idx] <= 1'b1;
                    cpu_read_data    <= req_wdata_q;
                    state_q          <= S_DONE;
                end
                S_DONE: begin
                    // Release only after done has been visible, so the CPU
                    // can never have a stale level re-accepted.
                    if (done_signal && !cpu_read && !cpu_write) begin
                        done_signal <= 1'b0;
                        cache_hit   <= 1'b0;
                        cache_miss  <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        done_signal <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: directed test-plan cases, a reset abort
// during a fill, then a randomized locality-bounded stream checked against a
// behavioural cache/memory model.
module tb_top_level;

    localparam int ML = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_address;
    logic [511:0] cpu_write_data;
    logic [511:0] cpu_read_data;
    logic         cache_hit;
    logic         cache_miss;
    logic         done_signal;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    always #5 clk = ~clk;

    top_level #(
        .NUM_LINES    (128),
        .MEM_LINE_BITS(12),
        .MEM_LATENCY  (ML)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_write_data(cpu_write_data),
        .cpu_read_data (cpu_read_data),
        .cache_hit     (cache_hit),
        .cache_miss    (cache_miss),
        .done_signal   (done_signal)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: cache contents per index plus sparse memory.
    bit           mv   [128];
    bit           md   [128];
    int unsigned  mt   [128];
    logic [511:0] mdat [128];
    logic [511:0] mm   [int unsigned];
    int           m_hits   = 0;
    int           m_misses = 0;
    int           nh = 0;
    int           nm = 0;

    function automatic logic [511:0] mem_get(input int unsigned li);
        if (mm.exists(li)) return mm[li];
        return '0;
    endfunction

    task automatic chk(input string nm_s, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm_s, act, exp);
        end
    endtask

    // Issue one request, predict its outcome from the model, check every cycle.
    task automatic do_req(input logic [31:0] a, input bit wr, input logic [511:0] d,
                          input int hold, output bit o_hit, output int o_lat,
                          output logic [511:0] o_data);
        int unsigned  la, idx, tg;
        bit           e_hit, e_dirty, seen;
        int           e_lat, k;
        logic [511:0] e_data;
        la      = a >> 6;
        idx     = la % 128;
        tg      = la / 128;
        e_hit   = mv[idx] && (mt[idx] == tg);
        e_dirty = !e_hit && mv[idx] && md[idx];
        if (e_hit) begin
            e_lat = 2;
            if (wr) begin
                mdat[idx] = d;
                md[idx]   = 1'b1;
            end
            m_hits++;
        end else begin
            if (e_dirty) mm[(mt[idx] * 128 + idx) % 4096] = mdat[idx];
            e_lat     = (wr ? 3 : 2 + ML) + (e_dirty ? ML : 0);
            mdat[idx] = wr ? d : mem_get(la % 4096);
            mv[idx]   = 1'b1;
            md[idx]   = wr;
            mt[idx]   = tg;
            m_misses++;
        end
        e_data = mdat[idx];

        @(negedge clk);
        cpu_address    = a;
        cpu_write      = wr;
        cpu_read       = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_write_data = wr ? d : {16{$urandom}};
        @(negedge clk);
        chk("accept_outputs", {cache_hit, cache_miss, done_signal}, 3'b000);
        k     = 0;
        seen  = 1'b0;
        o_lat = -1;
        o_hit = 1'b0;
        while (!seen && k < 60) begin
            k++;
            @(negedge clk);
            if (k == 1) begin
                o_hit = cache_hit;
                if (cache_hit && !cache_miss)      nh++;
                else if (cache_miss && !cache_hit) nm++;
            end
            chk("hit_miss", {cache_hit, cache_miss}, {e_hit, !e_hit});
            if (done_signal) begin
                seen  = 1'b1;
                o_lat = k;
            end
        end
        chk("latency", o_lat, e_lat);
        o_data = cpu_read_data;
        chk("read_data", cpu_read_data, e_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_outputs", {cache_hit, cache_miss, done_signal}, {e_hit, !e_hit, 1'b1});
            chk("hold_data", cpu_read_data, e_data);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        chk("release_outputs", {cache_hit, cache_miss, done_signal}, 3'b000);
        chk("data_held", cpu_read_data, e_data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           h;
        int           l;
        logic [511:0] d;
        logic [511:0] a5, ones, bb;
        a5   = {64{8'hA5}};
        ones = {128{4'h1}};
        bb   = {16{32'hB00C_0DE5}};

        rst            = 1'b1;
        cpu_read       = 1'b0;
        cpu_write      = 1'b0;
        cpu_address    = '0;
        cpu_write_data = '0;
        repeat (5) @(negedge clk);
        chk("reset_flags", {cache_hit, cache_miss, done_signal}, 3'b000);
        chk("reset_data", cpu_read_data, '0);
        rst = 1'b0;

        // Directed test-plan cases with hand-computed expectations.
        do_req(32'h1000_0000, 1'b0, '0, 0, h, l, d);
        chk("t1_hit", h, 1'b0);  chk("t1_lat", l, 6);  chk("t1_data", d, '0);
        do_req(32'h1000_0004, 1'b1, a5, 0, h, l, d);
        chk("t2_hit", h, 1'b1);  chk("t2_lat", l, 2);
        do_req(32'h1000_0030, 1'b0, '0, 0, h, l, d);
        chk("t3_hit", h, 1'b1);  chk("t3_data", d, a5);
        do_req(32'h1000_0000, 1'b1, ones, 0, h, l, d);
        chk("t4_hit", h, 1'b1);
        do_req(32'h1000_2000, 1'b0, '0, 0, h, l, d);
        chk("t5_hit", h, 1'b0);  chk("t5_lat", l, 10); chk("t5_data", d, '0);
        do_req(32'h1000_0000, 1'b0, '0, 0, h, l, d);
        chk("t6_hit", h, 1'b0);  chk("t6_lat", l, 6);  chk("t6_data", d, ones);
        do_req(32'h1000_0040, 1'b1, bb, 0, h, l, d);
        chk("t7_hit", h, 1'b0);  chk("t7_lat", l, 3);
        do_req(32'h1000_0040, 1'b0, '0, 3, h, l, d);
        chk("t8_hit", h, 1'b1);  chk("t8_data", d, bb);

        // Reset in the middle of a clean read-miss fill.
        @(negedge clk);
        cpu_address = 32'h1000_3000;
        cpu_read    = 1'b1;
        cpu_write   = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_miss", cache_miss, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("fill_reset_flags", {cache_hit, cache_miss, done_signal}, 3'b000);
        chk("fill_reset_data", cpu_read_data, '0);
        cpu_read = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
`ifdef CACHE_STATS_EN
        chk("stats_reset", {stat_hits, stat_misses}, 64'd0);
`endif
        do_req(32'h1000_3000, 1'b0, '0, 0, h, l, d);
        chk("t9_hit", h, 1'b0);  chk("t9_lat", l, 6);

        // Locality-bounded random stream: 64000-byte region, ~30% writes.
        nh = 0;
        nm = 0;
        for (int n = 0; n < 5000; n++) begin
            logic [31:0]  ra;
            bit           rw;
            logic [511:0] rdat;
            int           rh;
            ra   = 32'h1000_0000 + 32'($urandom_range(0, 63999));
            rw   = ($urandom_range(0, 99) < 30);
            rdat = {16{$urandom}};
            rh   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_req(ra, rw, rdat, rh, h, l, d);
        end
        chk("hits_plus_misses", nh + nm, 5000);
`ifdef CACHE_STATS_EN
        chk("stat_hits", stat_hits, m_hits);
        chk("stat_misses", stat_misses, m_misses);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
